// File: rtl/video_ntsc_pkg.sv
// Shared constants and types for the NTSC composite encoder: subcarrier
// phase increment, DAC reference levels, chroma scaling shift, the 16-entry
// signed sine table and the pipeline control-bit bundle.
package video_ntsc_pkg;

    // round(3.579545 MHz / 25 MHz * 2^24)
    localparam logic [23:0] PHASE_INC = 24'd2402192;

    localparam logic [4:0] LUMA_SYNC   = 5'd0;
    localparam logic [4:0] LUMA_BLANK  = 5'd9;
    localparam logic [3:0] CHROMA_ZERO = 4'd8;

    // Right shift applied to the U*sin + V*cos product sum
    localparam int CHROMA_SHIFT = 5;

    typedef logic signed [3:0] sin_t;

    // round(7 * sin(2*pi*k/16)), k = 0..15
    localparam sin_t SIN_TABLE [0:15] = '{
        4'sd0,  4'sd3,  4'sd5,  4'sd6,  4'sd7,  4'sd6,  4'sd5,  4'sd3,
        4'sd0, -4'sd3, -4'sd5, -4'sd6, -4'sd7, -4'sd6, -4'sd5, -4'sd3
    };

    // Control bits that travel alongside the video data
    typedef struct packed {
        logic active;
        logic burst;
        logic sync_n;
    } ctrl_t;

    localparam ctrl_t CTRL_BLANK = '{active: 1'b0, burst: 1'b0, sync_n: 1'b1};

    // Visible-pixel luma code: blank pedestal plus 1.5 * Y (range 9..31)
    function automatic logic [4:0] active_luma(input logic [3:0] y);
        return LUMA_BLANK + 5'(y) + 5'(y >> 1);
    endfunction

endpackage

// File: rtl/video_ntsc_sin_lut.sv
// Combinational 16-entry signed sine lookup (amplitude 7). Instantiated once
// for sine and once, with the index advanced a quarter turn, for cosine.
module video_ntsc_sin_lut
    import video_ntsc_pkg::*;
(
    input  logic [3:0] idx,
    output sin_t       value
);

    assign value = SIN_TABLE[idx];

endmodule

// File: rtl/video_ntsc_encoder.sv
// NTSC composite encoder: 4-bit RGB palette in, 5-bit luma-plus-sync and
// 4-bit chroma DAC codes out, with a fixed three-register pipeline.
//   Stage 1: Y/U/V colour-space conversion, control bits, subcarrier phase.
//   Stage 2: quadrature modulation C = (U*sin + V*cos) >>> 5.
//   Stage 3: sync/active/burst selection into the output registers.
// Build option: define VIDEO_NTSC_CHROMA_EN for the colour build (phase
// accumulator, sine/cosine LUTs, modulator). Without it the chroma output is
// the constant zero level and only the luma/sync path is built.
module video_ntsc_encoder
    import video_ntsc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    input  logic       active,
    input  logic       color_burst,
    input  logic       sync_n_in,
    output logic [4:0] luma,
    output logic       sync_n,
    output logic [3:0] chroma
);

    // ------------------------------------------------------------------
    // Stage 1 combinational: luminance weighting 77/150/29 out of 256
    // ------------------------------------------------------------------
    logic [11:0] y_sum;
    logic [3:0]  y_calc;
    ctrl_t       ctrl_in;

    assign y_sum   = 12'd77 * 12'(r) + 12'd150 * 12'(g) + 12'd29 * 12'(b);
    assign y_calc  = 4'(y_sum >> 8);
    assign ctrl_in = '{active: active, burst: color_burst, sync_n: sync_n_in};

    logic [3:0] s1_y;
    ctrl_t      s1_ctrl;
    logic [3:0] s2_y;
    ctrl_t      s2_ctrl;

    // Stage 1 register: luma and control bits
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    // NOTE: the data registers are reset as well as the control bits; this
    // keeps the outputs free of X straight out of reset at negligible cost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y    <= '0;
            s1_ctrl <= CTRL_BLANK;
        end else begin
            s1_y    <= y_calc;
            s1_ctrl <= ctrl_in;
        end
    end

    // Stage 2 register: luma and control bits carried alongside the modulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_y    <= '0;
            s2_ctrl <= CTRL_BLANK;
        end else begin
            s2_y    <= s1_y;
            s2_ctrl <= s1_ctrl;
        end
    end

    // Stage 3 register: luma level with sync taking priority over picture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma   <= LUMA_BLANK;
            sync_n <= 1'b1;
        end else begin
            sync_n <= s2_ctrl.sync_n;
            if (!s2_ctrl.sync_n) begin
                luma <= LUMA_SYNC;
            end else if (s2_ctrl.active) begin
                luma <= active_luma(s2_y);
            end else begin
                luma <= LUMA_BLANK;
            end
        end
    end

`ifdef VIDEO_NTSC_CHROMA_EN

    // ------------------------------------------------------------------
    // Colour path
    // ------------------------------------------------------------------
    logic [23:0]       phase;
    logic signed [4:0] u_calc;
    logic signed [4:0] v_calc;

    assign u_calc = $signed({1'b0, b}) - $signed({1'b0, y_calc});
    assign v_calc = $signed({1'b0, r}) - $signed({1'b0, y_calc});

    logic signed [4:0] s1_u;
    logic signed [4:0] s1_v;
    logic [3:0]        s1_idx;

    // Free-running subcarrier accumulator, wraps mod 2^24
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + PHASE_INC;
        end
    end

    // Stage 1 register: colour differences and the coarse phase index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_u   <= '0;
            s1_v   <= '0;
            s1_idx <= '0;
        end else begin
            s1_u   <= u_calc;
            s1_v   <= v_calc;
            s1_idx <= phase[23:20];
        end
    end

    sin_t sin_val;
    sin_t cos_val;

    video_ntsc_sin_lut u_sin_lut (
        .idx   (s1_idx),
        .value (sin_val)
    );

    video_ntsc_sin_lut u_cos_lut (
        .idx   (4'(s1_idx + 4'd4)),
        .value (cos_val)
    );

    // Products span +/-105 each, so the sum fits comfortably in 10 signed bits
    logic signed [9:0] mix;
    assign mix = 10'(s1_u) * 10'(sin_val) + 10'(s1_v) * 10'(cos_val);

    sin_t s2_c;
    sin_t s2_sin;

    // Stage 2 register: modulated chroma and the sine sample for the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_c   <= '0;
            s2_sin <= '0;
        end else begin
            s2_c   <= 4'(mix >>> CHROMA_SHIFT);
            s2_sin <= sin_val;
        end
    end

    logic signed [5:0] chroma_sum;
    logic [3:0]        chroma_next;

    // Stage 3 selection: sync, then picture, then burst, then zero level
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        chroma_sum  = 6'sd8 + 6'(s2_c);
        chroma_next = CHROMA_ZERO;
        if (!s2_ctrl.sync_n) begin
            chroma_next = CHROMA_ZERO;
        end else if (s2_ctrl.active) begin
            if (chroma_sum < 6'sd0) begin
                chroma_next = 4'd0;
            end else if (chroma_sum > 6'sd15) begin
                chroma_next = 4'd15;
            end else begin
                chroma_next = chroma_sum[3:0];
            end
        end else if (s2_ctrl.burst) begin
            chroma_next = 4'(6'sd8 - 6'(s2_sin >>> 1));
        end
    end

    // Stage 3 register: chroma output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chroma <= CHROMA_ZERO;
        end else begin
            chroma <= chroma_next;
        end
    end

`else

    // Monochrome build: no subcarrier, chroma sits at the zero level
    assign chroma = CHROMA_ZERO;

    // The burst flag still travels the pipeline but has no consumer here
    logic unused_burst;
    assign unused_burst = s2_ctrl.burst;

`endif

endmodule

// File: tb/tb_video_ntsc_encoder.sv
// Self-checking bench for video_ntsc_encoder. A behavioural model computes
// each expected output from the input sample and the number of clocks since
// reset release (which fixes the subcarrier phase); expectations sit in a
// queue three registers deep and are compared one tick after each edge.
module tb_video_ntsc_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] r, g, b;
    logic       active, color_burst, sync_n_in;
    logic [4:0] luma;
    logic       sync_n;
    logic [3:0] chroma;

    video_ntsc_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r           (r),
        .g           (g),
        .b           (b),
        .active      (active),
        .color_burst (color_burst),
        .sync_n_in   (sync_n_in),
        .luma        (luma),
        .sync_n      (sync_n),
        .chroma      (chroma)
    );

    // 25 MHz
    always #20 clk = ~clk;

    localparam longint PHASE_STEP = 2402192;
    localparam longint PHASE_MOD  = 64'd16777216;

    typedef struct {
        int luma;
        int sync_n;
        int chroma;
    } exp_t;

    exp_t   exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    longint edge_n   = 0;

    function automatic int floor_div(input int x, input int d);
        return int'($floor(real'(x) / real'(d)));
    endfunction

    function automatic int sin7(input int k);
        real x;
        x = 7.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 16.0);
        return int'($floor(x + 0.5));
    endfunction

    function automatic exp_t model(input int ri, input int gi, input int bi,
                                   input int act, input int bur, input int syn,
                                   input longint n);
        exp_t e;
        int   y;
        y = (77 * ri + 150 * gi + 29 * bi) / 256;
        e.sync_n = syn;
        if (syn == 0)      e.luma = 0;
        else if (act != 0) e.luma = 9 + y + y / 2;
        else               e.luma = 9;
        e.chroma = 8;
`ifdef VIDEO_NTSC_CHROMA_EN
        begin
            int k, s, c, cc;
            k  = int'(((n * PHASE_STEP) % PHASE_MOD) / 1048576);
            s  = sin7(k);
            c  = sin7((k + 4) % 16);
            cc = floor_div((bi - y) * s + (ri - y) * c, 32);
            if (syn == 0) begin
                e.chroma = 8;
            end else if (act != 0) begin
                e.chroma = (8 + cc < 0) ? 0 : (8 + cc > 15) ? 15 : 8 + cc;
            end else if (bur != 0) begin
                e.chroma = 8 - floor_div(s, 2);
            end
        end
`else
        if (n < 0) e.chroma = 8;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_luma"},   32'(luma),   32'd9);
        check({tag, "_sync"},   32'(sync_n), 32'd1);
        check({tag, "_chroma"}, 32'(chroma), 32'd8);
    endtask

    // Called #1 after a rising edge: apply inputs, clock once, compare
    task automatic drive_cycle(input int ri, input int gi, input int bi,
                               input int act, input int bur, input int syn);
        exp_t e;
        r = 4'(ri); g = 4'(gi); b = 4'(bi);
        active = act[0]; color_burst = bur[0]; sync_n_in = syn[0];
        exp_q.push_back(model(ri, gi, bi, act, bur, syn, edge_n));
        edge_n++;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check("luma",   32'(luma),   32'(e.luma));
        check("sync_n", 32'(sync_n), 32'(e.sync_n));
        check("chroma", 32'(chroma), 32'(e.chroma));
    endtask

    task automatic rand_cycle();
        drive_cycle(int'($urandom_range(15)), int'($urandom_range(15)),
                    int'($urandom_range(15)), int'($urandom_range(1)),
                    int'($urandom_range(1)), int'($urandom_range(7) != 0));
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after an edge
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check_blank("reset_async");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_blank("reset_hold");
        end
        rst_n = 1'b1;
        exp_q.delete();
        // Two pipeline stages still hold reset contents after release
        for (int i = 0; i < 2; i++) exp_q.push_back('{luma: 9, sync_n: 1, chroma: 8});
        edge_n = 0;
    endtask

    int sync_low_cnt;

    initial begin
        rst_n = 1'b0;
        r = '0; g = '0; b = '0;
        active = 1'b0; color_burst = 1'b0; sync_n_in = 1'b1;

        // Reset state, then idle blanking after release
        @(posedge clk); #1;
        do_reset(3);
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 0, 0, 1);

        // Red pixel immediately after reset: phase index 0
        @(posedge clk); #1;
        do_reset(2);
        drive_cycle(15, 0, 0, 1, 0, 1);
        drive_cycle(15, 0, 0, 1, 0, 1);
        drive_cycle(15, 0, 0, 1, 0, 1);
        check("red_first_luma", 32'(luma), 32'd15);
`ifdef VIDEO_NTSC_CHROMA_EN
        check("red_first_chroma", 32'(chroma), 32'd10);
`else
        check("red_first_chroma", 32'(chroma), 32'd8);
`endif
        for (int i = 0; i < 4; i++) drive_cycle(15, 0, 0, 1, 0, 1);

        // White and black
        for (int i = 0; i < 6; i++) drive_cycle(15, 15, 15, 1, 0, 1);
        check("white_luma", 32'(luma), 32'd31);
        for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 1, 0, 1);
        check("black_luma", 32'(luma), 32'd9);

        // Horizontal sync pulse of 118 clocks; burst asserted too but overridden
        sync_low_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            drive_cycle(7, 7, 7, 0, (i % 3 == 0) ? 1 : 0, (i < 118) ? 0 : 1);
            if (sync_n === 1'b0) sync_low_cnt++;
        end
        check("sync_low_count", 32'(sync_low_cnt), 32'd118);

        // Colour burst window
        for (int i = 0; i < 64; i++) drive_cycle(0, 0, 0, 0, 1, 1);

        // Active and burst together: picture wins
        for (int i = 0; i < 16; i++)
            drive_cycle(int'($urandom_range(15)), int'($urandom_range(15)),
                        int'($urandom_range(15)), 1, 1, 1);

        // Random picture, including per-clock toggling of every control input
        for (int i = 0; i < 300; i++) rand_cycle();

        // Reset mid-line with picture in flight: nothing stale may emerge
        do_reset(1);
        for (int i = 0; i < 200; i++) rand_cycle();
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
